// File: rtl/uart_term_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_term_pkg
// Description : Shared state encoding and character constants for the
//               UART terminal screen writer.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_term_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PUT      = 2'd1,
        CLR_LINE = 2'd2,
        CLR_ALL  = 2'd3
    } state_t;

    localparam logic [7:0] CH_SPACE    = 8'h20;
    localparam logic [7:0] CH_CR       = 8'h0D;
    localparam logic [7:0] CH_LF       = 8'h0A;
    localparam logic [7:0] CH_BS       = 8'h08;
    localparam logic [7:0] CH_FF       = 8'h0C;
    localparam logic [7:0] CH_PRINT_LO = 8'h20;
    localparam logic [7:0] CH_PRINT_HI = 8'h7E;

    // True for bytes that are drawn as glyphs at the cursor
    function automatic logic is_printable(input logic [7:0] b);
        return (b >= CH_PRINT_LO) && (b <= CH_PRINT_HI);
    endfunction

endpackage
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : byte_fifo
// Description : Small power-of-two FIFO with head data always presented on
//               rdata_o. A push on a full FIFO is accepted only when a pop
//               happens on the same edge.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Storage array; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_screen_writer.sv
`default_nettype none
// ============================================================================
// Module      : uart_screen_writer
// Description : Turns received UART bytes into screen-buffer character writes
//               with a terminal cursor (CR, LF, BS, FF handling, row clear on
//               wrap, full clear after reset).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_screen_writer
    import uart_term_pkg::*;
#(
    parameter int COLS           = 16,
    parameter int ROWS           = 4,
    parameter int IDX_W          = 6,
    parameter int FIFO_DEPTH     = 4,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             scr_we,
    output logic [IDX_W-1:0] scr_index,
    output logic [7:0]       scr_char,
    output logic [IDX_W-1:0] cursor_index,
    output logic             busy,
    output logic             overflow
);
    // Cursor is {row, col}; COLS and ROWS are powers of two since their
    // product is 2**IDX_W, so row*COLS+col is a plain concatenation.
    localparam int                COL_W    = $clog2(COLS);
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(COLS - 1);
    localparam logic [IDX_W-1:0]  COL_MASK = IDX_W'(COLS - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = {IDX_W{1'b1}};
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cursor_q, cursor_d;
    logic [IDX_W-1:0] cursor_nxt_q, cursor_nxt_d;   // cursor applied when PUT ends
    logic             wrap_q, wrap_d;               // PUT is followed by a row clear
    logic             init_clr_q, init_clr_d;       // full clear pending after reset
    logic             we_q, we_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       chr_q, chr_d;
    logic             ovf_q;

    logic [7:0]                  fifo_data;
    logic                        fifo_empty, fifo_full, fifo_pop, fifo_push;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic [COL_W-1:0]            cur_col;
    logic [IDX_W-1:0]            next_row_home;

    assign cur_col       = cursor_q[COL_W-1:0];
    assign next_row_home = (cursor_q | COL_MASK) + IDX_ONE;   // col 0, row+1 mod ROWS
    assign fifo_push     = rx_valid && (!fifo_full || fifo_pop);

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .wdata_i (rx_data),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_data),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    assign scr_we       = we_q;
    assign scr_index    = idx_q;
    assign scr_char     = chr_q;
    assign cursor_index = cursor_q;
    assign overflow     = ovf_q;
    assign busy         = (state_q != IDLE) || (fifo_count != '0);

    // Next-state, cursor and write-port decode; a write is scheduled on the
    // edge that enters the cycle in which scr_we is high.
    always_comb begin
        state_d      = state_q;
        cursor_d     = cursor_q;
        cursor_nxt_d = cursor_nxt_q;
        wrap_d       = wrap_q;
        init_clr_d   = init_clr_q;
        we_d         = 1'b0;
        idx_d        = idx_q;
        chr_d        = chr_q;
        fifo_pop     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (init_clr_q) begin
                    init_clr_d = 1'b0;
                    state_d    = CLR_ALL;
                    cursor_d   = '0;
                    we_d       = 1'b1;
                    idx_d      = '0;
                    chr_d      = CH_SPACE;
                end else if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (is_printable(fifo_data)) begin
                        state_d      = PUT;
                        we_d         = 1'b1;
                        idx_d        = cursor_q;
                        chr_d        = fifo_data;
                        cursor_nxt_d = cursor_q + IDX_ONE;
                        wrap_d       = (cur_col == COL_LAST);
                    end else begin
                        case (fifo_data)
                            CH_CR: cursor_d = cursor_q & ~COL_MASK;
                            CH_LF: begin
                                cursor_d = next_row_home;
                                state_d  = CLR_LINE;
                                we_d     = 1'b1;
                                idx_d    = next_row_home;
                                chr_d    = CH_SPACE;
                            end
                            CH_BS: begin
                                if (cur_col != '0) begin
                                    state_d      = PUT;
                                    we_d         = 1'b1;
                                    idx_d        = cursor_q - IDX_ONE;
                                    chr_d        = CH_SPACE;
                                    cursor_nxt_d = cursor_q - IDX_ONE;
                                    wrap_d       = 1'b0;
                                end
                            end
                            CH_FF: begin
                                cursor_d = '0;
                                state_d  = CLR_ALL;
                                we_d     = 1'b1;
                                idx_d    = '0;
                                chr_d    = CH_SPACE;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            PUT: begin
                cursor_d = cursor_nxt_q;
                if (wrap_q) begin
                    state_d = CLR_LINE;
                    we_d    = 1'b1;
                    idx_d   = cursor_nxt_q;
                    chr_d   = CH_SPACE;
                end else begin
                    state_d = IDLE;
                end
            end
            CLR_LINE: begin
                if (idx_q[COL_W-1:0] == COL_LAST) begin
                    state_d = IDLE;
                end else begin
                    we_d  = 1'b1;
                    idx_d = idx_q + IDX_ONE;
                end
            end
            CLR_ALL: begin
                if (idx_q == IDX_LAST) begin
                    state_d  = IDLE;
                    cursor_d = '0;
                end else begin
                    we_d  = 1'b1;
                    idx_d = idx_q + IDX_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, cursor, registered write port and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cursor_q     <= '0;
            cursor_nxt_q <= '0;
            wrap_q       <= 1'b0;
            init_clr_q   <= (CLEAR_ON_RESET != 0);
            we_q         <= 1'b0;
            idx_q        <= '0;
            chr_q        <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cursor_q     <= cursor_d;
            cursor_nxt_q <= cursor_nxt_d;
            wrap_q       <= wrap_d;
            init_clr_q   <= init_clr_d;
            we_q         <= we_d;
            idx_q        <= idx_d;
            chr_q        <= chr_d;
            ovf_q        <= ovf_q | (rx_valid && !fifo_push);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_screen_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_screen_writer
// Description : Self-checking bench; a terminal-level reference model
//               predicts the sequence of screen writes and the cursor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_screen_writer;
    localparam int COLS = 16;
    localparam int ROWS = 4;
    localparam int NCH  = COLS * ROWS;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       scr_we;
    logic [5:0] scr_index;
    logic [7:0] scr_char;
    logic [5:0] cursor_index;
    logic       busy;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    logic [13:0] got_q[$];
    logic [13:0] exp_q[$];
    int          m_row, m_col;
    logic        m_ovf;

    uart_screen_writer #(
        .COLS(16), .ROWS(4), .IDX_W(6), .FIFO_DEPTH(4), .CLEAR_ON_RESET(1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .scr_we       (scr_we),
        .scr_index    (scr_index),
        .scr_char     (scr_char),
        .cursor_index (cursor_index),
        .busy         (busy),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    // Record every screen write seen on the port
    always @(negedge clk) begin
        if (rst_n === 1'b1 && scr_we === 1'b1) got_q.push_back({scr_index, scr_char});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- terminal reference model ----------------
    function automatic void m_clear_row(input int r);
        for (int c = 0; c < COLS; c++) exp_q.push_back({6'(r * COLS + c), 8'h20});
    endfunction

    function automatic void m_reset();
        m_row = 0; m_col = 0; m_ovf = 1'b0;
        for (int i = 0; i < NCH; i++) exp_q.push_back({6'(i), 8'h20});
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            exp_q.push_back({6'(m_row * COLS + m_col), b});
            if (m_col == COLS - 1) begin
                m_col = 0; m_row = (m_row + 1) % ROWS; m_clear_row(m_row);
            end else m_col++;
        end else if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h0A) begin
            m_col = 0; m_row = (m_row + 1) % ROWS; m_clear_row(m_row);
        end else if (b == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                exp_q.push_back({6'(m_row * COLS + m_col), 8'h20});
            end
        end else if (b == 8'h0C) begin
            for (int i = 0; i < NCH; i++) exp_q.push_back({6'(i), 8'h20});
            m_row = 0; m_col = 0;
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic compare();
        int n;
        wait_idle();
        chk("wr_count", got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk($sformatf("wr%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
        chk("cursor", 32'(cursor_index), 32'(m_row * COLS + m_col));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data = b; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        model_byte(b);
        wait_idle();
    endtask

    function automatic logic [7:0] rand_byte();
        int r = $urandom_range(0, 9);
        if (r <= 5) return 8'($urandom_range(8'h20, 8'h7E));
        if (r == 6) return 8'h0D;
        if (r == 7) return 8'h0A;
        if (r == 8) return 8'h08;
        if ($urandom_range(0, 3) == 0) return 8'h0C;
        return 8'($urandom_range(8'h7F, 8'hFF));
    endfunction

    task automatic rand_bursts(input int nb);
        logic [7:0] b;
        int len;
        for (int k = 0; k < nb; k++) begin
            len = $urandom_range(1, 4);
            for (int j = 0; j < len; j++) begin
                @(negedge clk);
                b = rand_byte();
                rx_data = b; rx_valid = 1'b1;
                model_byte(b);
            end
            @(negedge clk);
            rx_valid = 1'b0;
            compare();
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_we"},     32'(scr_we), 32'd0);
        chk({tag, "_idx"},    32'(scr_index), 32'd0);
        chk({tag, "_chr"},    32'(scr_char), 32'd0);
        chk({tag, "_cursor"}, 32'(cursor_index), 32'd0);
        chk({tag, "_busy"},   32'(busy), 32'd0);
        chk({tag, "_ovf"},    32'(overflow), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        m_row = 0; m_col = 0; m_ovf = 1'b0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");

        // Release reset: full clear of the screen
        rst_n = 1'b1;
        m_reset();
        compare();
        chk("busy_after_clear", 32'(busy), 32'd0);

        // 'A' with cycle-exact latency
        @(negedge clk);
        rx_data = 8'h41; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        chk("lat_cycle1_we", 32'(scr_we), 32'd0);
        @(negedge clk);
        chk("lat_cycle2_we", 32'(scr_we), 32'd1);
        chk("lat_cycle2_idx", 32'(scr_index), 32'd0);
        chk("lat_cycle2_chr", 32'(scr_char), 32'h41);
        model_byte(8'h41);
        compare();

        // 17 printables from home: wrap clears row 1
        send(8'h0D);
        for (int i = 0; i < 17; i++) send(8'(8'h61 + i));
        compare();

        // Backspace / carriage return at cursor 5
        send(8'h0C);
        for (int i = 0; i < 5; i++) send(8'h30);
        compare();
        send(8'h08); compare();
        send(8'h0D); compare();
        send(8'h08); compare();

        // LF from row 3 col 2 wraps to row 0
        send(8'h0A); send(8'h0A); send(8'h0A);
        send(8'h78); send(8'h79);
        compare();
        send(8'h0A);
        compare();

        // Randomized traffic
        rand_bursts(30);

        // FF, then 6 bytes back-to-back during the clear: 4 kept, 2 dropped
        @(negedge clk);
        rx_data = 8'h0C; rx_valid = 1'b1;
        model_byte(8'h0C);
        @(negedge clk); rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            rx_data = 8'(8'h61 + i); rx_valid = 1'b1;
            if (i < 4) model_byte(8'(8'h61 + i));
            @(negedge clk);
        end
        rx_valid = 1'b0;
        m_ovf = 1'b1;
        chk("ovf_set", 32'(overflow), 32'd1);
        compare();

        // Reset in the middle of a full clear
        send(8'h0C);
        @(negedge clk);
        rx_data = 8'h0C; rx_valid = 1'b1;
        @(negedge clk); rx_valid = 1'b0;
        repeat (10) @(negedge clk);
        @(posedge clk);
        #2;
        chk("pre_reset_we", 32'(scr_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midclr");
        got_q.delete();
        exp_q.delete();
        repeat (3) begin
            @(negedge clk);
            chk("held_we", 32'(scr_we), 32'd0);
        end
        chk("held_nowrites", got_q.size(), 32'd0);
        rst_n = 1'b1;
        m_reset();
        compare();

        rand_bursts(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
